sar_adc_scan: RTL and testbench

Multi-channel successive-approximation ADC sequencer, the parametrised successor to the single-channel ADC/DAC loop in the PROM top level. It drives an external analog mux select and a parallel DAC code, samples the external comparator (`gtRef`), and scans a masked set of channels in single-shot or continuous mode. Per-channel results are held in a register file with a read port, so the seven-segment and game logic can read them without stalling conversion.

---
 rtl/sar_adc_scan.sv | 166 ++++++++++++++++
 tb/tb_sar_adc_scan.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_scan.sv
// Multi-channel successive-approximation ADC sequencer: scans a masked channel set,
// drives mux select and DAC trial codes, and keeps per-channel results readable at any time.
`timescale 1ns/1ps
module sar_adc_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SETTLE   = 2,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                start,
    input  logic                continuous,
    input  logic [CHANNELS-1:0] chMask,
    input  logic                gtRef,
    output logic [WIDTH-1:0]    dacCode,
    output logic [CHW-1:0]      chSel,
    output logic                busy,
    output logic                done,
    input  logic [CHW-1:0]      rdAddr,
    output logic [WIDTH-1:0]    rdData,
    output logic                rdValid
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_MUX, S_TRIAL, S_STORE, S_DONE} state_t;

    state_t                state_reg, state_next;
    logic [CHANNELS-1:0]   mask_reg, mask_next;
    logic [CHW-1:0]        chsel_reg, chsel_next;
    logic [WIDTH-1:0]      acc_reg, acc_next;
    logic [BW-1:0]         bit_reg, bit_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [CHANNELS-1:0]   above;
    logic [WIDTH-1:0]      result_reg [CHANNELS];
    logic                  valid_reg  [CHANNELS];

    function automatic logic [CHW-1:0] lowest(input logic [CHANNELS-1:0] m);
        lowest = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) lowest = CHW'(i);
        end
    endfunction

    // Enabled channels strictly above the one currently being converted.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_above
            assign above[gi] = mask_reg[gi] && (chsel_reg < CHW'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg <= S_IDLE;
            mask_reg  <= '0;
            chsel_reg <= '0;
            acc_reg   <= '0;
            bit_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            chsel_reg <= chsel_next;
            acc_reg   <= acc_next;
            bit_reg   <= bit_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        chsel_next = chsel_reg;
        acc_next   = acc_reg;
        bit_next   = bit_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && (chMask != '0)) begin
                    mask_next  = chMask;
                    chsel_next = lowest(chMask);
                    cnt_next   = '0;
                    state_next = S_MUX;
                end
            end
            S_MUX: begin
                acc_next = '0;
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    bit_next   = BIT_MSB;
                    state_next = S_TRIAL;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_TRIAL: begin
                // Comparator is sampled only at the end of the settle window.
                if (cnt_reg == CNT_LAST) begin
                    cnt_next          = '0;
                    acc_next[bit_reg] = gtRef;
                    if (bit_reg == '0) state_next = S_STORE;
                    else               bit_next   = bit_reg - 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_STORE: begin
                if (above != '0) begin
                    chsel_next = lowest(above);
                    cnt_next   = '0;
                    state_next = S_MUX;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (continuous && (chMask != '0)) begin
                    mask_next  = chMask;
                    chsel_next = lowest(chMask);
                    cnt_next   = '0;
                    state_next = S_MUX;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_result
            always_ff @(posedge CLK or negedge Reset) begin
                if (!Reset) begin
                    result_reg[gi] <= '0;
                    valid_reg[gi]  <= 1'b0;
                end else if ((state_reg == S_STORE) && (chsel_reg == CHW'(gi))) begin
                    result_reg[gi] <= acc_reg;
                    valid_reg[gi]  <= 1'b1;
                end
            end
        end
    endgenerate

    // Addresses beyond the last channel match no entry and read as zero.
    always_comb begin
        rdData  = '0;
        rdValid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rdAddr == CHW'(i)) begin
                rdData  = result_reg[i];
                rdValid = valid_reg[i];
            end
        end
    end

    assign dacCode = (state_reg == S_TRIAL) ? (acc_reg | (WIDTH'(1) << bit_reg)) : '0;
    assign chSel   = chsel_reg;
    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_DONE);

endmodule

// File: tb/tb_sar_adc_scan.sv
// Directed bench for sar_adc_scan: comparator modelled as vin[chSel] >= dacCode.
`timescale 1ns/1ps
module tb_sar_adc_scan;

    logic       CLK = 1'b0;
    logic       Reset, start, continuous, gtRef, busy, done, rdValid;
    logic [3:0] chMask;
    logic [7:0] dacCode, rdData;
    logic [1:0] chSel, rdAddr;
    logic [7:0] vin [4];

    int checks = 0;
    int errors = 0;
    int         chsel_log[$];
    logic [7:0] dac_log[$];

    sar_adc_scan #(.WIDTH(8), .CHANNELS(4), .SETTLE(2)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .continuous(continuous),
        .chMask(chMask), .gtRef(gtRef), .dacCode(dacCode), .chSel(chSel),
        .busy(busy), .done(done), .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid)
    );

    always #5 CLK = ~CLK;
    assign gtRef = (vin[chSel] >= dacCode);

    // Starts a scan and counts busy cycles; logs chSel changes and trial codes of one channel.
    task automatic scan(input logic [3:0] mask, input int trace_ch, input int poke_at,
                        output int busy_cyc, output int done_cyc, output int done_n);
        logic [7:0] prev_dac = 8'h00;
        int prev_sel = -1;
        chsel_log.delete();
        dac_log.delete();
        @(negedge CLK);
        chMask = mask;
        start  = 1'b1;
        @(negedge CLK);
        start    = 1'b0;
        busy_cyc = 0;
        done_cyc = 0;
        done_n   = 0;
        while (busy && busy_cyc < 1000) begin
            busy_cyc++;
            if (done) begin
                done_cyc = busy_cyc;
                done_n++;
            end
            if (int'(chSel) != prev_sel) begin
                chsel_log.push_back(int'(chSel));
                prev_sel = int'(chSel);
            end
            if (int'(chSel) == trace_ch && dacCode != 8'h00 && dacCode != prev_dac)
                dac_log.push_back(dacCode);
            prev_dac = dacCode;
            start = (busy_cyc == poke_at);
            @(negedge CLK);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b0; continuous = 1'b0; chMask = 4'h0; rdAddr = 2'd0;
        vin[0] = 8'h00; vin[1] = 8'h00; vin[2] = 8'h00; vin[3] = 8'h00;
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dacCode !== 8'h00 || chSel !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b dac=%h chSel=%0d, want 0 0 00 0",
                     busy, done, dacCode, chSel);
        end
        for (int c = 0; c < 4; c++) begin
            rdAddr = 2'(c);
            #1;
            checks++;
            if (rdData !== 8'h00 || rdValid !== 1'b0) begin
                errors++;
                $display("FAIL reset_read ch%0d: data=%h valid=%b, want 00 0", c, rdData, rdValid);
            end
        end
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic test_single();
        int bc, dc, dn;
        vin[2] = 8'hA5;
        scan(4'b0100, -1, 0, bc, dc, dn);
        checks++;
        if (bc !== 20 || dc !== 20 || dn !== 1) begin
            errors++;
            $display("FAIL single_timing: busy=%0d done_at=%0d pulses=%0d, want 20 20 1", bc, dc, dn);
        end
        for (int c = 0; c < 4; c++) begin
            rdAddr = 2'(c);
            #1;
            checks++;
            if (rdData !== ((c == 2) ? 8'hA5 : 8'h00) || rdValid !== (c == 2)) begin
                errors++;
                $display("FAIL single_read ch%0d: data=%h valid=%b, want %h %b",
                         c, rdData, rdValid, (c == 2) ? 8'hA5 : 8'h00, c == 2);
            end
        end
    endtask

    task automatic test_full();
        int bc, dc, dn;
        logic [7:0] exp_res [4]   = '{8'h00, 8'hFF, 8'h80, 8'h7F};
        logic [7:0] exp_trace [8] = '{8'h80, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81};
        vin[0] = 8'h00; vin[1] = 8'hFF; vin[2] = 8'h80; vin[3] = 8'h7F;
        scan(4'b1111, 2, 0, bc, dc, dn);
        checks++;
        if (bc !== 77 || dc !== 77 || dn !== 1) begin
            errors++;
            $display("FAIL full_timing: busy=%0d done_at=%0d pulses=%0d, want 77 77 1", bc, dc, dn);
        end
        checks++;
        if (chsel_log.size() != 4 || chsel_log[0] != 0 || chsel_log[1] != 1 ||
            chsel_log[2] != 2 || chsel_log[3] != 3) begin
            errors++;
            $display("FAIL full_chsel_order: got %p, want 0 1 2 3", chsel_log);
        end
        checks++;
        if (dac_log.size() != 8) begin
            errors++;
            $display("FAIL full_trace_len: got %0d codes, want 8", dac_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (dac_log[i] !== exp_trace[i]) begin
                    errors++;
                    $display("FAIL full_trace[%0d]: got %h, want %h", i, dac_log[i], exp_trace[i]);
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            rdAddr = 2'(c);
            #1;
            checks++;
            if (rdData !== exp_res[c] || rdValid !== 1'b1) begin
                errors++;
                $display("FAIL full_read ch%0d: data=%h valid=%b, want %h 1", c, rdData, rdValid, exp_res[c]);
            end
        end
    endtask

    task automatic test_sparse();
        int bc, dc, dn;
        logic [7:0] exp_res [4] = '{8'h00, 8'h22, 8'h80, 8'h44};
        vin[0] = 8'h11; vin[1] = 8'h22; vin[2] = 8'h33; vin[3] = 8'h44;
        scan(4'b1010, -1, 10, bc, dc, dn);
        checks++;
        if (bc !== 39 || dc !== 39 || dn !== 1) begin
            errors++;
            $display("FAIL sparse_timing: busy=%0d done_at=%0d pulses=%0d, want 39 39 1", bc, dc, dn);
        end
        checks++;
        if (chsel_log.size() != 2 || chsel_log[0] != 1 || chsel_log[1] != 3) begin
            errors++;
            $display("FAIL sparse_chsel_order: got %p, want 1 3", chsel_log);
        end
        for (int c = 0; c < 4; c++) begin
            rdAddr = 2'(c);
            #1;
            checks++;
            if (rdData !== exp_res[c] || rdValid !== 1'b1) begin
                errors++;
                $display("FAIL sparse_read ch%0d: data=%h valid=%b, want %h 1", c, rdData, rdValid, exp_res[c]);
            end
        end
        @(negedge CLK);
        chMask = 4'b0000;
        start  = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_mask_start: busy=%b, want 0", busy);
        end
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || dacCode !== 8'h00) begin
            errors++;
            $display("FAIL zero_mask_idle: busy=%b dac=%h, want 0 00", busy, dacCode);
        end
    endtask

    task automatic test_continuous();
        int cyc = 0, ndone = 0, t1 = 0, t2 = 0, t3 = 0;
        rdAddr = 2'd0;
        vin[0] = 8'h10;
        continuous = 1'b1;
        @(negedge CLK);
        chMask = 4'b0001;
        start  = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        while (busy && cyc < 300) begin
            cyc++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = cyc;
                    checks++;
                    if (rdData !== 8'h10 || rdValid !== 1'b1) begin
                        errors++;
                        $display("FAIL cont_result1: data=%h valid=%b, want 10 1", rdData, rdValid);
                    end
                    vin[0] = 8'h20;
                end else if (ndone == 2) begin
                    t2 = cyc;
                    checks++;
                    if (rdData !== 8'h20) begin
                        errors++;
                        $display("FAIL cont_result2: data=%h, want 20", rdData);
                    end
                end else begin
                    t3 = cyc;
                end
            end
            if (ndone == 2 && cyc == t2 + 5) continuous = 1'b0;
            @(negedge CLK);
        end
        continuous = 1'b0;
        checks++;
        if (ndone !== 3 || t1 !== 20 || t2 - t1 !== 20 || t3 - t2 !== 20) begin
            errors++;
            $display("FAIL cont_done_spacing: pulses=%0d at %0d %0d %0d, want 3 at 20 40 60",
                     ndone, t1, t2, t3);
        end
        checks++;
        if (cyc !== 60) begin
            errors++;
            $display("FAIL cont_busy_span: busy=%0d cycles, want 60 unbroken", cyc);
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        int bc, dc, dn;
        logic [7:0] exp_res [4] = '{8'h5A, 8'hC3, 8'h01, 8'hFE};
        vin[0] = 8'h11; vin[1] = 8'h22; vin[2] = 8'h33; vin[3] = 8'h44;
        @(negedge CLK);
        chMask = 4'b1111;
        start  = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        while (!(chSel == 2'd1 && dacCode != 8'h00) && cnt < 200) begin
            @(negedge CLK);
            cnt++;
        end
        checks++;
        if (cnt >= 200) begin
            errors++;
            $display("FAIL reset_mid_reach: ch1 trial not seen within %0d cycles", cnt);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dacCode !== 8'h00 || chSel !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%b dac=%h chSel=%0d done=%b, want 0 00 0 0",
                     busy, dacCode, chSel, done);
        end
        for (int c = 0; c < 4; c++) begin
            rdAddr = 2'(c);
            #0.5;
            checks++;
            if (rdData !== 8'h00 || rdValid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_read ch%0d: data=%h valid=%b, want 00 0", c, rdData, rdValid);
            end
        end
        @(negedge CLK);
        Reset = 1'b1;
        vin[0] = 8'h5A; vin[1] = 8'hC3; vin[2] = 8'h01; vin[3] = 8'hFE;
        scan(4'b1111, -1, 0, bc, dc, dn);
        checks++;
        if (bc !== 77 || dc !== 77 || dn !== 1) begin
            errors++;
            $display("FAIL post_reset_timing: busy=%0d done_at=%0d pulses=%0d, want 77 77 1", bc, dc, dn);
        end
        for (int c = 0; c < 4; c++) begin
            rdAddr = 2'(c);
            #1;
            checks++;
            if (rdData !== exp_res[c] || rdValid !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_read ch%0d: data=%h valid=%b, want %h 1",
                         c, rdData, rdValid, exp_res[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_sparse();
        test_continuous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
